// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Multi-lane parking admission controller. It keeps a registered free-space
// count and arbitrates simultaneous entry requests round-robin. At most one
// car is admitted per cycle. Each admitted lane's gate is held open for a
// fixed number of cycles, and departing cars credit a space back.
//
// Parameters
//   CAP_W            : width of the free-space count
//   CAPACITY         : total spaces (1 .. 2**CAP_W-1)
//   LANES            : number of entry lanes (1 .. 8)
//   GATE_OPEN_CYCLES : cycles a gate stays open after a grant (>= 1)
//
// Ports
//   i_clk              : clock, rising edge
//   i_rst_n            : synchronous active-low reset
//   i_entry            : per-lane car-present level
//   i_exit             : one-cycle pulse per departing car
//   o_parking_capacity : registered free-space count
//   o_enable           : one-hot, one-cycle grant pulse
//   o_reject           : one-cycle pulse per refused lane
//   o_gate_open        : per-lane gate drive
//   o_full             : high when the free-space count is zero
//   o_exit_err         : pulse when an exit arrives with no car in the lot
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
  parameter int CAP_W            = 8,
  parameter int CAPACITY         = 200,
  parameter int LANES            = 2,
  parameter int GATE_OPEN_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [LANES-1:0] i_entry,
  input  logic             i_exit,
  output logic [CAP_W-1:0] o_parking_capacity,
  output logic [LANES-1:0] o_enable,
  output logic [LANES-1:0] o_reject,
  output logic [LANES-1:0] o_gate_open,
  output logic             o_full,
  output logic             o_exit_err
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int TMR_W = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

  localparam logic [CAP_W-1:0] CAP_MAX  = CAP_W'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(GATE_OPEN_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LANES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OPEN = 1'b1
  } lane_state_t;

  // Registered state
  lane_state_t      r_state [LANES];
  logic [TMR_W-1:0] r_timer [LANES];
  logic [PTR_W-1:0] r_ptr;
  logic [CAP_W-1:0] r_count;
  logic [LANES-1:0] r_elig_hist;
  logic [LANES-1:0] r_enable;
  logic [LANES-1:0] r_reject;
  logic             r_exit_err;

  // Combinational decisions for the current cycle
  logic [LANES-1:0] w_elig;
  logic [LANES-1:0] w_grant;
  logic [LANES-1:0] w_reject;
  logic             w_any_grant;
  logic [PTR_W-1:0] w_gidx;
  logic [PTR_W-1:0] w_ptr_next;
  logic [CAP_W-1:0] w_count_next;
  logic             w_exit_err;

  // Saturating count update: the count is held inside [0, CAPACITY].
  // A grant never happens at zero, and an unpaired exit at CAPACITY is blocked.
  function automatic logic [CAP_W-1:0] f_next_count(
    input logic [CAP_W-1:0] cnt,
    input logic             grant,
    input logic             ext
  );
    logic [CAP_W-1:0] res;
    res = cnt;
    if (grant && !ext) begin
      res = cnt - 1'b1;
    end else if (ext && !grant && (cnt != CAP_MAX)) begin
      res = cnt + 1'b1;
    end
    return res;
  endfunction

  // An exit with no matching grant while every space is already free means
  // the sensor reported a car that was never admitted.
  function automatic logic f_exit_err(
    input logic [CAP_W-1:0] cnt,
    input logic             grant,
    input logic             ext
  );
    return ext && !grant && (cnt == CAP_MAX);
  endfunction

  // A lane can only request while its gate is closed.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < LANES; i++) begin
      w_elig[i] = i_entry[i] && (r_state[i] == ST_IDLE);
    end
  end

  // Round-robin search: first eligible lane at or after r_ptr, wrapping.
  always_comb begin : arb
    int               idx;
    logic [PTR_W-1:0] idx_p;
    idx         = 0;
    idx_p       = '0;
    w_any_grant = 1'b0;
    w_gidx      = '0;
    w_grant     = '0;
    if (r_count != '0) begin
      for (int k = 0; k < LANES; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= LANES) begin
          idx = idx - LANES;
        end
        idx_p = PTR_W'(idx);
        if (!w_any_grant && w_elig[idx_p]) begin
          w_any_grant = 1'b1;
          w_gidx      = idx_p;
        end
      end
    end
    if (w_any_grant) begin
      w_grant[w_gidx] = 1'b1;
    end
  end

  assign w_ptr_next = (w_gidx == PTR_LAST) ? '0 : (w_gidx + 1'b1);

  // Reject only when eligibility rises, so a car waiting at a full lot
  // produces a single pulse rather than one per cycle.
  assign w_reject = (r_count == '0) ? (w_elig & ~r_elig_hist) : '0;

  assign w_count_next = f_next_count(r_count, w_any_grant, i_exit);
  assign w_exit_err   = f_exit_err(r_count, w_any_grant, i_exit);

  always_ff @(posedge i_clk) begin
    // Gate timers carry no meaning while the lane is idle, so they are
    // loaded on grant and left out of reset.
    for (int i = 0; i < LANES; i++) begin
      if (w_grant[i]) begin
        r_timer[i] <= TMR_LOAD;
      end else if ((r_state[i] == ST_OPEN) && (r_timer[i] != '0)) begin
        r_timer[i] <= r_timer[i] - 1'b1;
      end
    end

    if (!i_rst_n) begin
      r_count     <= CAP_MAX;
      r_ptr       <= '0;
      r_elig_hist <= '0;
      r_enable    <= '0;
      r_reject    <= '0;
      r_exit_err  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_state[i] <= ST_IDLE;
      end
    end else begin
      r_count     <= w_count_next;
      r_elig_hist <= w_elig;
      r_enable    <= w_grant;
      r_reject    <= w_reject;
      r_exit_err  <= w_exit_err;
      if (w_any_grant) begin
        r_ptr <= w_ptr_next;
      end
      for (int i = 0; i < LANES; i++) begin
        case (r_state[i])
          ST_IDLE: begin
            if (w_grant[i]) begin
              r_state[i] <= ST_OPEN;
            end
          end
          ST_OPEN: begin
            if (r_timer[i] == '0) begin
              r_state[i] <= ST_IDLE;
            end
          end
          default: r_state[i] <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_gate_open = '0;
    for (int i = 0; i < LANES; i++) begin
      o_gate_open[i] = (r_state[i] == ST_OPEN);
    end
  end

  assign o_parking_capacity = r_count;
  assign o_enable           = r_enable;
  assign o_reject           = r_reject;
  assign o_exit_err         = r_exit_err;
  assign o_full             = (r_count == '0);

endmodule
